rename_rollback: RTL and testbench
==================================

# rename_rollback

Walks the rename history backward after a pipeline flush and emits, youngest group first, the register-name/tag pairs that restore the rename map to its pre-flush state. It drives the rename history's read port (sqN in; NUM_UOPS consecutive {regNm, tag} entries out, combinational) and feeds restore writes to the rename map. It sits beside the rename stage and is idle except during recovery.

## Interface
- NUM_UOPS, 3: lanes per history read and per restore beat.
- NUM_ENTRIES, 32: history depth; the history is indexed by sqN[$clog2(NUM_ENTRIES)-1:0].
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- IN_flushValid  in  1  flush request this cycle.
- IN_flushSqN  in  6  sqN of the oldest squashed uop.
- IN_curSqN  in  6  next sqN to be allocated (youngest+1); sampled only when a flush is accepted in IDLE.
- OUT_readSqN  out  6  history read address; lane i returns entry readSqN+i.
- IN_readRegNm  in  NUM_UOPS*6  history regNm, lane i at [i*6+:6].
- IN_readRegTag  in  NUM_UOPS*7  history tag, lane i at [i*7+:7].
- OUT_restoreValid  out  NUM_UOPS  per-lane restore strobe.
- OUT_restoreRegNm  out  NUM_UOPS*6  register to restore.
- OUT_restoreTag  out  NUM_UOPS*7  tag to write.
- OUT_busy  out  1  rollback in progress; rename must stall.
- OUT_done  out  1  one-cycle pulse: rollback complete.

## Operation
- Registers: state {IDLE, WALK, DRAIN}, ptr (6b, exclusive upper sqN still to restore), tgt (6b, latched flushSqN). remaining = (ptr - tgt) mod 64, 6-bit. All sqN arithmetic is mod 64.
- IDLE: on IN_flushValid, ptr <= IN_curSqN, tgt <= IN_flushSqN, go WALK. Callers guarantee remaining <= NUM_ENTRIES.
- WALK, each cycle: g = min(remaining, NUM_UOPS); OUT_readSqN = ptr - g; lanes 0..g-1 active; ptr <= ptr - g. If remaining == 0 at WALK entry, no read occurs: go DRAIN with no restore beat.
- Next state after a read: WALK if new remaining > 0, else DRAIN.
- Lane qualification (registered into the restore outputs): lane i valid iff i < g, regNm != 0, and no lane j < i (older) in the same group is valid with the same regNm. The older lane wins because the history holds the mapping prior to each uop.
- DRAIN: last restore beat visible; OUT_done = 1; next state IDLE.
- Flush while busy (WALK or DRAIN): if (IN_flushSqN - tgt) as signed 6-bit < 0 (older), then tgt <= IN_flushSqN and the walk extends. A DRAIN cycle that sees an extension goes to WALK and suppresses OUT_done. A younger or equal flush is ignored. The extension applies after the same cycle's ptr update.
- OUT_readSqN = ptr in IDLE and DRAIN (don't-care to the history).

## Timing
- Reset: state IDLE, ptr = tgt = 0, OUT_restoreValid = 0, restore data 0, OUT_busy = 0, OUT_done = 0. A reset mid-walk aborts immediately with no further beats.
- Flush accepted at cycle T. OUT_busy is high from T+1 through the OUT_done cycle inclusive.
- N = ceil(count/NUM_UOPS) reads occur in cycles T+1..T+N. Restore beats are registered and appear in cycles T+2..T+N+1. OUT_done coincides with the last beat at T+N+1.
- count = 0: OUT_done at T+1 with no restore beats.
- Back-to-back: a flush in the cycle after OUT_done is accepted normally.

## Test plan
- Flush 10, cur 17: readSqN 14, 11, 10 in T+1..T+3 (last beat lane0 only). Beats at T+2..T+4; done at T+4; busy T+1..T+4.
- Flush 20, cur 20: no restoreValid; done and busy at T+1 only.
- Wrap: flush 62, cur 2: readSqN 63 (entries 63, 0, 1), then 62 lane0. Done at T+3.
- Group 14..16 = {r5/t40, r5/t41, r0/t9}: restoreValid = 3'b001, regNm 5, tag 40.
- Flush 10, cur 17, then flush 4 at T+2: reads 14, 11, 8, 5, 4; done at T+6. A flush of 15 at T+2 instead is ignored (done at T+4).
- rst asserted at T+2 of a 7-entry walk: all outputs 0 that cycle. Afterwards the block stays IDLE with no done pulse.

Source files
------------

// File: rtl/rename_rollback.sv
// rename_rollback: after a pipeline flush, walks the rename history backward from the youngest
// allocated sqN down to the oldest squashed sqN. It emits restore writes for the rename map,
// youngest group first, NUM_UOPS lanes per beat.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   IN_flushValid     flush request this cycle
//   IN_flushSqN       sqN of the oldest squashed uop
//   IN_curSqN         next sqN to be allocated; sampled only when a flush is accepted in idle
//   OUT_readSqN       history read address; lane i returns entry OUT_readSqN+i
//   IN_readRegNm      history regNm per lane, lane i at [i*6+:6]
//   IN_readRegTag     history tag per lane, lane i at [i*7+:7]
//   OUT_restoreValid  per-lane restore strobe (registered)
//   OUT_restoreRegNm  register to restore, per lane
//   OUT_restoreTag    tag to write, per lane
//   OUT_busy          rollback in progress; rename must stall
//   OUT_done          one-cycle pulse on the final restore beat
module rename_rollback #(
  parameter int unsigned NUM_UOPS    = 3,
  parameter int unsigned NUM_ENTRIES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  IN_flushValid,
  input  logic [5:0]            IN_flushSqN,
  input  logic [5:0]            IN_curSqN,
  output logic [5:0]            OUT_readSqN,
  input  logic [NUM_UOPS*6-1:0] IN_readRegNm,
  input  logic [NUM_UOPS*7-1:0] IN_readRegTag,
  output logic [NUM_UOPS-1:0]   OUT_restoreValid,
  output logic [NUM_UOPS*6-1:0] OUT_restoreRegNm,
  output logic [NUM_UOPS*7-1:0] OUT_restoreTag,
  output logic                  OUT_busy,
  output logic                  OUT_done
);

  typedef enum logic [1:0] {StIdle, StWalk, StDrain} state_e;

  localparam logic [5:0] GrpMax = 6'(NUM_UOPS);

  state_e     state_q, state_d;
  logic [5:0] ptr_q, ptr_d;
  logic [5:0] tgt_q, tgt_d;
  logic [5:0] remaining;
  logic [5:0] grp;
  logic [5:0] flush_delta;
  logic       older_flush;

  logic [NUM_UOPS-1:0]   valid_d, valid_q;
  logic [NUM_UOPS*6-1:0] nm_d, nm_q;
  logic [NUM_UOPS*7-1:0] tag_d, tag_q;

  // sqN arithmetic wraps mod 64; ptr is the exclusive upper bound still to restore.
  assign remaining   = ptr_q - tgt_q;
  assign grp         = (remaining > GrpMax) ? GrpMax : remaining;
  // A flush strictly older than the current target (signed distance < 0) extends the walk.
  assign flush_delta = IN_flushSqN - tgt_q;
  assign older_flush = IN_flushValid & flush_delta[5];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    tgt_d       = tgt_q;
    OUT_readSqN = ptr_q;
    OUT_done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (IN_flushValid) begin
          ptr_d   = IN_curSqN;
          tgt_d   = IN_flushSqN;
          // Nothing to restore: complete on the very next cycle.
          state_d = (IN_curSqN == IN_flushSqN) ? StDrain : StWalk;
        end
      end
      StWalk: begin
        OUT_readSqN = ptr_q - grp;
        ptr_d       = ptr_q - grp;
        // Extension is applied after this cycle's pointer step.
        if (older_flush) tgt_d = IN_flushSqN;
        state_d = (ptr_d != tgt_d) ? StWalk : StDrain;
      end
      StDrain: begin
        if (older_flush) begin
          tgt_d   = IN_flushSqN;
          state_d = StWalk;
        end else begin
          OUT_done = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Lane qualification: within a group the oldest lane writing a register wins, since the
  // history holds the mapping that preceded each uop.
  always_comb begin
    valid_d = '0;
    nm_d    = '0;
    tag_d   = '0;
    if (state_q == StWalk) begin
      nm_d  = IN_readRegNm;
      tag_d = IN_readRegTag;
      for (int i = 0; i < NUM_UOPS; i++) begin
        valid_d[i] = (6'(i) < grp) && (IN_readRegNm[i*6+:6] != 6'd0);
        for (int j = 0; j < i; j++) begin
          if (valid_d[j] && (IN_readRegNm[j*6+:6] == IN_readRegNm[i*6+:6])) valid_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      tgt_q   <= '0;
      valid_q <= '0;
      nm_q    <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tgt_q   <= tgt_d;
      valid_q <= valid_d;
      nm_q    <= nm_d;
      tag_q   <= tag_d;
    end
  end

  assign OUT_restoreValid = valid_q;
  assign OUT_restoreRegNm = nm_q;
  assign OUT_restoreTag   = tag_q;
  assign OUT_busy         = (state_q != StIdle);

  // The walk never spans more than the history holds.
  walk_within_history: assert property (@(posedge clk) disable iff (rst)
    (state_q == StWalk) |-> (32'(remaining) <= NUM_ENTRIES));

endmodule

// File: tb/tb_rename_rollback.sv
module tb_rename_rollback;

  logic        clk = 1'b0;
  logic        rst;
  logic        IN_flushValid;
  logic [5:0]  IN_flushSqN;
  logic [5:0]  IN_curSqN;
  logic [5:0]  OUT_readSqN;
  logic [17:0] IN_readRegNm;
  logic [20:0] IN_readRegTag;
  logic [2:0]  OUT_restoreValid;
  logic [17:0] OUT_restoreRegNm;
  logic [20:0] OUT_restoreTag;
  logic        OUT_busy;
  logic        OUT_done;

  int checks   = 0;
  int failures = 0;

  logic [5:0] hist_nm [32];
  logic [6:0] hist_tg [32];

  typedef struct {
    logic        busy;
    logic        done;
    logic        rd_chk;
    logic [5:0]  rd;
    logic [2:0]  v;
    logic [17:0] nm;
    logic [20:0] tg;
  } exp_t;

  exp_t exp_q[$];

  rename_rollback #(.NUM_UOPS(3), .NUM_ENTRIES(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .IN_flushValid    (IN_flushValid),
    .IN_flushSqN      (IN_flushSqN),
    .IN_curSqN        (IN_curSqN),
    .OUT_readSqN      (OUT_readSqN),
    .IN_readRegNm     (IN_readRegNm),
    .IN_readRegTag    (IN_readRegTag),
    .OUT_restoreValid (OUT_restoreValid),
    .OUT_restoreRegNm (OUT_restoreRegNm),
    .OUT_restoreTag   (OUT_restoreTag),
    .OUT_busy         (OUT_busy),
    .OUT_done         (OUT_done)
  );

  always #5 clk = ~clk;

  // History memory: combinational read of three consecutive entries.
  always_comb begin
    IN_readRegNm  = '0;
    IN_readRegTag = '0;
    for (int i = 0; i < 3; i++) begin
      IN_readRegNm[i*6+:6]  = hist_nm[5'(OUT_readSqN + 6'(i))];
      IN_readRegTag[i*7+:7] = hist_tg[5'(OUT_readSqN + 6'(i))];
    end
  end

  task automatic init_hist();
    for (int i = 0; i < 32; i++) begin
      hist_nm[i] = 6'((i * 5) % 9);
      hist_tg[i] = 7'(i + 64);
    end
    // Group 14..16 = {r5/t40, r5/t41, r0/t9}
    hist_nm[14] = 6'd5; hist_tg[14] = 7'd40;
    hist_nm[15] = 6'd5; hist_tg[15] = 7'd41;
    hist_nm[16] = 6'd0; hist_tg[16] = 7'd9;
  endtask

  // Expected per-cycle outputs from T+1 onward for a walk from cur down to flush.
  function automatic void push_walk(input logic [5:0] cur, input logic [5:0] flush);
    int         cnt, n, size;
    logic [5:0] top, rd, sq, nm;
    logic [2:0] pv;
    logic [17:0] pnm;
    logic [20:0] ptg;
    logic       dup;
    exp_t       e;
    logic [5:0] diff;
    diff = cur - flush;
    cnt  = int'(diff);
    if (cnt == 0) begin
      e.busy = 1'b1; e.done = 1'b1; e.rd_chk = 1'b0; e.rd = '0;
      e.v = '0; e.nm = '0; e.tg = '0;
      exp_q.push_back(e);
      return;
    end
    n = (cnt + 2) / 3;
    pv = '0; pnm = '0; ptg = '0;
    top = cur;
    for (int k = 0; k <= n; k++) begin
      e.busy = 1'b1;
      e.done = (k == n);
      e.v = pv; e.nm = pnm; e.tg = ptg;
      e.rd_chk = 1'b0;
      e.rd = '0;
      if (k < n) begin
        size = (cnt - 3 * k > 3) ? 3 : cnt - 3 * k;
        rd = top - 6'(size);
        e.rd_chk = 1'b1;
        e.rd = rd;
        pv = '0; pnm = '0; ptg = '0;
        for (int i = 0; i < size; i++) begin
          sq = rd + 6'(i);
          nm = hist_nm[sq[4:0]];
          dup = 1'b0;
          for (int j = 0; j < i; j++) if (pv[j] && pnm[j*6+:6] == nm) dup = 1'b1;
          if (nm != 6'd0 && !dup) begin
            pv[i] = 1'b1;
            pnm[i*6+:6] = nm;
            ptg[i*7+:7] = hist_tg[sq[4:0]];
          end
        end
        top = rd;
      end
      exp_q.push_back(e);
    end
  endfunction

  task automatic start_flush(input logic [5:0] cur, input logic [5:0] flush);
    @(negedge clk);
    IN_flushValid = 1'b1;
    IN_flushSqN   = flush;
    IN_curSqN     = cur;
  endtask

  // Pops one expected record per cycle; optionally drives a second flush in cycle T+1+ext_k.
  task automatic run_walk(input string name, input int ext_k, input logic [5:0] ext_sqn);
    int    k;
    exp_t  e;
    logic [17:0] nmask;
    logic [20:0] tmask;
    k = 0;
    while (exp_q.size() > 0) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
        nmask[i*6+:6] = {6{e.v[i]}};
        tmask[i*7+:7] = {7{e.v[i]}};
      end
      checks++;
      if (OUT_busy !== e.busy) begin
        failures++;
        $display("FAIL %s c%0d busy got %0b want %0b", name, k, OUT_busy, e.busy);
      end
      checks++;
      if (OUT_done !== e.done) begin
        failures++;
        $display("FAIL %s c%0d done got %0b want %0b", name, k, OUT_done, e.done);
      end
      if (e.rd_chk) begin
        checks++;
        if (OUT_readSqN !== e.rd) begin
          failures++;
          $display("FAIL %s c%0d readSqN got %0d want %0d", name, k, OUT_readSqN, e.rd);
        end
      end
      checks++;
      if (OUT_restoreValid !== e.v) begin
        failures++;
        $display("FAIL %s c%0d valid got %b want %b", name, k, OUT_restoreValid, e.v);
      end
      checks++;
      if ((OUT_restoreRegNm & nmask) !== e.nm || (OUT_restoreTag & tmask) !== e.tg) begin
        failures++;
        $display("FAIL %s c%0d data got nm %h tag %h want nm %h tag %h", name, k,
                 OUT_restoreRegNm & nmask, OUT_restoreTag & tmask, e.nm, e.tg);
      end
      @(negedge clk);
      IN_flushValid = (k == ext_k);
      IN_flushSqN   = ext_sqn;
      k++;
    end
    @(posedge clk); #1;
    checks++;
    if (OUT_busy !== 1'b0 || OUT_done !== 1'b0 || OUT_restoreValid !== 3'b000) begin
      failures++;
      $display("FAIL %s idle-after got busy %0b done %0b valid %b want 0 0 000", name,
               OUT_busy, OUT_done, OUT_restoreValid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    IN_flushValid = 1'b0; IN_flushSqN = '0; IN_curSqN = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({OUT_busy, OUT_done, OUT_restoreValid, OUT_restoreRegNm, OUT_restoreTag, OUT_readSqN}
        !== '0) begin
      failures++;
      $display("FAIL reset outputs got busy %0b done %0b valid %b nm %h tag %h rd %0d want 0",
               OUT_busy, OUT_done, OUT_restoreValid, OUT_restoreRegNm, OUT_restoreTag,
               OUT_readSqN);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    push_walk(6'd17, 6'd10);
    start_flush(6'd17, 6'd10);
    run_walk("basic", -1, 6'd0);
  endtask

  task automatic test_empty();
    push_walk(6'd20, 6'd20);
    start_flush(6'd20, 6'd20);
    run_walk("empty", -1, 6'd0);
  endtask

  task automatic test_wrap();
    push_walk(6'd2, 6'd62);
    start_flush(6'd2, 6'd62);
    run_walk("wrap", -1, 6'd0);
  endtask

  task automatic test_extend();
    push_walk(6'd17, 6'd4);
    start_flush(6'd17, 6'd10);
    run_walk("extend", 1, 6'd4);
  endtask

  task automatic test_ignore_younger();
    push_walk(6'd17, 6'd10);
    start_flush(6'd17, 6'd10);
    run_walk("ignore", 1, 6'd15);
  endtask

  task automatic test_random();
    logic [5:0] cur, cnt;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 32; i++) begin
        hist_nm[i] = 6'($urandom_range(0, 5));
        hist_tg[i] = 7'($urandom_range(0, 127));
      end
      cur = 6'($urandom_range(0, 63));
      cnt = 6'($urandom_range(1, 32));
      push_walk(cur, cur - cnt);
      start_flush(cur, cur - cnt);
      run_walk("random", -1, 6'd0);
    end
  endtask

  task automatic test_reset_midwalk();
    init_hist();
    start_flush(6'd17, 6'd10);
    @(posedge clk);
    @(negedge clk);
    IN_flushValid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (OUT_restoreValid !== 3'b001 || OUT_restoreRegNm[5:0] !== 6'd5 ||
        OUT_restoreTag[6:0] !== 7'd40) begin
      failures++;
      $display("FAIL midwalk first-beat got valid %b nm %0d tag %0d want 001 5 40",
               OUT_restoreValid, OUT_restoreRegNm[5:0], OUT_restoreTag[6:0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({OUT_busy, OUT_done, OUT_restoreValid, OUT_restoreRegNm, OUT_restoreTag, OUT_readSqN}
        !== '0) begin
      failures++;
      $display("FAIL midwalk reset got busy %0b done %0b valid %b want all 0",
               OUT_busy, OUT_done, OUT_restoreValid);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++;
      if (OUT_busy !== 1'b0 || OUT_done !== 1'b0 || OUT_restoreValid !== 3'b000) begin
        failures++;
        $display("FAIL midwalk after-reset c%0d got busy %0b done %0b valid %b want 0 0 000",
                 c, OUT_busy, OUT_done, OUT_restoreValid);
      end
    end
  endtask

  initial begin
    init_hist();
    test_reset();
    test_basic();
    test_empty();
    test_wrap();
    test_extend();
    test_ignore_younger();
    test_random();
    test_reset_midwalk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
